// File: rtl/jtag_driver.sv
// jtag_driver: JTAG master sequencer feeding a TAP controller.
// Turns RESET / SHIFT_IR / SHIFT_DR / IDLE commands into TCK/TMS/TDI
// waveforms, captures TDO during shifts and returns it as a one-cycle response.
// Optional feature macro: JTAG_TRST_EN (adds the TRST port and a TRST pulse
// ahead of every TAP reset sequence).
module jtag_driver #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = $clog2(DATA_W) + 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [1:0]        CMD_OP,
    input  logic [LEN_W-1:0]  CMD_LEN,
    input  logic [DATA_W-1:0] CMD_DATA,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic              BUSY,
    output logic              TCK,
    output logic              TMS,
    output logic              TDI,
    input  logic              TDO
`ifdef JTAG_TRST_EN
    ,
    output logic              TRST
`endif
);

    localparam int PH_W  = $clog2(2 * CLK_DIV + 1);
    localparam int CNT_W = $clog2(DATA_W + 8);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_DR    = 2'd2;
    localparam logic [1:0] OP_IDLE  = 2'd3;

    localparam logic [PH_W-1:0] PH_RISE = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_END  = PH_W'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRST,
        S_PRE,
        S_SHIFT,
        S_POST,
        S_WAIT
    } state_t;

    state_t              st_q, st_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    cnt_t                bit_q, bit_d;
    logic [1:0]          op_q, op_d;
    cnt_t                len_q, len_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   cap_q, cap_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                ready_q, ready_d;
    logic                auto_q, auto_d;
    logic                tck_q, tck_d;
    logic                tms_q, tms_d;
    logic                tdi_q, tdi_d;
`ifdef JTAG_TRST_EN
    logic                trst_q, trst_d;
`endif

    // Scratch values for the bit-boundary decision.
    state_t              nst;
    cnt_t                nbit;
    logic                done;
    cnt_t                pre_last;
    cnt_t                last_bit;
    logic [LEN_W-1:0]    len_clamp;

    // Over-long requests shift at most DATA_W bits.
    assign len_clamp = (CMD_LEN > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : CMD_LEN;

    // Index of the final PRE bit: 6-bit TAP reset, 4-bit IR entry, 3-bit DR entry.
    assign pre_last = (op_q == OP_RESET) ? cnt_t'(5) :
                      (op_q == OP_IR)    ? cnt_t'(3) : cnt_t'(2);
    assign last_bit = len_q - cnt_t'(1);

    // TMS value driven for bit b of state s.
    function automatic logic tms_for(input state_t s, input logic [1:0] op,
                                     input cnt_t b, input cnt_t lastb);
        logic t;
        t = 1'b0;
        case (s)
            S_PRE: begin
                if (op == OP_RESET)   t = (b < cnt_t'(5));
                else if (op == OP_IR) t = (b < cnt_t'(2));
                else                  t = (b == cnt_t'(0));
            end
            S_SHIFT: t = (b == lastb);
            S_POST:  t = (b == cnt_t'(0));
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // Next-state and output decode; outputs are all registered one edge later.
    always_comb begin
        st_d        = st_q;
        ph_d        = ph_q;
        bit_d       = bit_q;
        op_d        = op_q;
        len_d       = len_q;
        data_d      = data_q;
        cap_d       = cap_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        ready_d     = ready_q;
        auto_d      = auto_q;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
`ifdef JTAG_TRST_EN
        trst_d      = trst_q;
`endif
        nst         = st_q;
        nbit        = bit_q;
        done        = 1'b0;

        case (st_q)
            S_IDLE: begin
                tck_d = 1'b0;
                tms_d = 1'b0;
                tdi_d = 1'b0;
                if (CMD_VALID && ready_q) begin
                    op_d   = CMD_OP;
                    data_d = CMD_DATA;
                    len_d  = cnt_t'(len_clamp);
                    cap_d  = '0;
                    ph_d   = '0;
                    bit_d  = '0;
                    if (CMD_OP == OP_RESET) begin
                        ready_d = 1'b0;
                        tms_d   = 1'b1;
`ifdef JTAG_TRST_EN
                        st_d    = S_TRST;
                        trst_d  = 1'b1;
`else
                        st_d    = S_PRE;
`endif
                    end else if (len_clamp == '0) begin
                        // Zero-length: nothing to clock, answer immediately.
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                    end else begin
                        ready_d = 1'b0;
                        st_d    = (CMD_OP == OP_IDLE) ? S_WAIT : S_PRE;
                        tms_d   = (CMD_OP != OP_IDLE);
                    end
                end
            end
`ifdef JTAG_TRST_EN
            S_TRST: begin
                // TRST held for one full TCK period with TCK low. Coming out of
                // RST the pulse has not started yet, so raise it first.
                tck_d = 1'b0;
                if (!trst_q) begin
                    trst_d = 1'b1;
                    ph_d   = '0;
                end else if (ph_q == PH_END) begin
                    trst_d = 1'b0;
                    ph_d   = '0;
                    bit_d  = '0;
                    st_d   = S_PRE;
                    tms_d  = 1'b1;
                    tdi_d  = 1'b0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
`endif
            default: begin
                ph_d = ph_q + PH_W'(1);
                // TCK rising edge: TDO is taken on this same CLK edge.
                if (ph_q == PH_RISE) begin
                    tck_d = 1'b1;
                    if (st_q == S_SHIFT) cap_d[bit_q[IDX_W-1:0]] = TDO;
                end
                // TCK falling edge: end of bit, choose the next bit's TMS/TDI.
                if (ph_q == PH_END) begin
                    ph_d  = '0;
                    tck_d = 1'b0;
                    nbit  = bit_q + cnt_t'(1);
                    case (st_q)
                        S_PRE: begin
                            if (bit_q == pre_last) begin
                                if (op_q == OP_RESET) begin
                                    done = 1'b1;
                                end else begin
                                    nst  = S_SHIFT;
                                    nbit = '0;
                                end
                            end
                        end
                        S_SHIFT: begin
                            if (bit_q == last_bit) begin
                                nst  = S_POST;
                                nbit = '0;
                            end
                        end
                        S_POST:  if (bit_q == cnt_t'(1)) done = 1'b1;
                        S_WAIT:  if (bit_q == last_bit) done = 1'b1;
                        default: done = 1'b1;
                    endcase

                    if (done) begin
                        st_d    = S_IDLE;
                        bit_d   = '0;
                        ready_d = 1'b1;
                        tms_d   = 1'b0;
                        tdi_d   = 1'b0;
                        auto_d  = 1'b0;
                        // The power-on reset sequence is silent.
                        if (!auto_q) begin
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = cap_q;
                        end
                    end else begin
                        st_d  = nst;
                        bit_d = nbit;
                        tms_d = tms_for(nst, op_q, nbit, last_bit);
                        tdi_d = (nst == S_SHIFT) ? data_q[nbit[IDX_W-1:0]] : 1'b0;
                    end
                end
            end
        endcase
    end

    // State and output registers; RST restarts the TAP reset sequence.
    always_ff @(posedge CLK) begin
        if (RST) begin
`ifdef JTAG_TRST_EN
            st_q   <= S_TRST;
            trst_q <= 1'b0;
`else
            st_q   <= S_PRE;
`endif
            ph_q        <= '0;
            bit_q       <= '0;
            op_q        <= OP_RESET;
            len_q       <= '0;
            data_q      <= '0;
            cap_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            auto_q      <= 1'b1;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
        end else begin
            st_q        <= st_d;
            ph_q        <= ph_d;
            bit_q       <= bit_d;
            op_q        <= op_d;
            len_q       <= len_d;
            data_q      <= data_d;
            cap_q       <= cap_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            ready_q     <= ready_d;
            auto_q      <= auto_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
`ifdef JTAG_TRST_EN
            trst_q      <= trst_d;
`endif
        end
    end

    assign CMD_READY = ready_q;
    assign BUSY      = ~ready_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;
    assign TCK       = tck_q;
    assign TMS       = tms_q;
    assign TDI       = tdi_q;
`ifdef JTAG_TRST_EN
    assign TRST      = trst_q;
`endif

endmodule

// File: tb/tb_jtag_driver.sv
// Scoreboard bench for jtag_driver: the driver pushes expected responses,
// a monitor records TMS/TDI at each TCK rise and checks on RSP_VALID.
module tb_jtag_driver;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_DR    = 2'd2;
    localparam logic [1:0] OP_IDLE  = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [3:0] cmd_len = 4'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       tck, tms, tdi;
    logic       dly = 1'b0;
`ifdef JTAG_TRST_EN
    logic       trst;
`endif

    jtag_driver #(.DATA_W(8), .CLK_DIV(2)) dut (
        .CLK(clk), .RST(rst),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
        .CMD_OP(cmd_op), .CMD_LEN(cmd_len), .CMD_DATA(cmd_data),
        .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data), .BUSY(busy),
        .TCK(tck), .TMS(tms), .TDI(tdi), .TDO(dly)
`ifdef JTAG_TRST_EN
        , .TRST(trst)
`endif
    );

    always #5 clk = ~clk;

    // TAP stand-in: TDO is TDI delayed by one TCK.
    always @(posedge tck) dly <= tdi;

    typedef struct {
        logic [7:0]  data;
        int          ntck;
        logic [31:0] tms;
        logic [31:0] tdi;
        bit          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_rsp = 0;
    int          cyc = 0;
    int          last_rsp_cyc = -10;
    int          rec_n = 0;
    logic [31:0] rec_tms = '0;
    logic [31:0] rec_tdi = '0;
    logic        tck_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input int n, input logic [31:0] t,
                                input logic [31:0] i, input bit lat);
        exp_t e;
        e.data = d; e.ntck = n; e.tms = t; e.tdi = i; e.lat = lat; e.acc = 0;
        return e;
    endfunction

    task automatic rec_clear();
        rec_n = 0; rec_tms = '0; rec_tdi = '0;
    endtask

    always @(posedge clk) cyc++;

    // Monitor: log TMS/TDI per TCK rise, check each response against the scoreboard.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (tck && !tck_prev) begin
            if (rec_n < 32) begin
                rec_tms[rec_n] = tms;
                rec_tdi[rec_n] = tdi;
            end
            rec_n++;
        end
        tck_prev = tck;
        if (rsp_valid) begin
            n_rsp++;
            if (sb.size() == 0) begin
                chk("unexpected_rsp_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
                chk("tck_count", rec_n, e.ntck);
                chk("tms_seq", rec_tms, e.tms);
                chk("tdi_seq", rec_tdi, e.tdi);
                chk("rsp_ready", {31'd0, cmd_ready}, 32'd1);
                if (e.lat) chk("rsp_latency", cyc, e.acc);
            end
            last_rsp_cyc = cyc;
            rec_clear();
        end
    end

    // Present a command (caller is at a negedge) and wait until it is accepted.
    task automatic send(input logic [1:0] op, input logic [3:0] len, input logic [7:0] data,
                        input exp_t e, input bit hold, input bit b2b);
        int w = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
        while (!cmd_ready && w < 3000) begin @(negedge clk); w++; end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        e.acc = cyc + 1;
        if (b2b) chk("b2b_accept_cycle", e.acc, last_rsp_cyc + 1);
        sb.push_back(e);
        @(negedge clk);
        if (!hold) begin
            // Scramble inputs after accept; the DUT must have latched them.
            cmd_valid = 1'b0; cmd_op = ~op; cmd_data = ~data; cmd_len = ~len;
        end
    endtask

    task automatic wait_done();
        int w = 0;
        while ((sb.size() != 0 || !cmd_ready) && w < 3000) begin @(negedge clk); w++; end
        if (w >= 3000) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!cmd_ready && w < 3000) begin @(negedge clk); w++; end
        if (w >= 3000) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n0;
        int w;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tck", {31'd0, tck}, 32'd0);
        chk("reset_tms", {31'd0, tms}, 32'd1);
        chk("reset_tdi", {31'd0, tdi}, 32'd0);
        chk("reset_ready", {31'd0, cmd_ready}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_data", {24'd0, rsp_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rec_clear();

        // Power-on TAP reset: 6 TCK, TMS 1,1,1,1,1,0, no response.
        wait_ready();
        chk("auto_tck_count", rec_n, 32'd6);
        chk("auto_tms_seq", rec_tms, 32'h1F);
        chk("auto_busy", {31'd0, busy}, 32'd0);
        rec_clear();

        // SHIFT_IR len 4, data 0010.
        send(OP_IR, 4'd4, 8'h02, mk(8'h04, 10, 32'h183, 32'h20, 0), 0, 0);
        wait_done();

        // SHIFT_DR len 8, data 0x81; loopback gives 0x02.
        send(OP_DR, 4'd8, 8'h81, mk(8'h02, 13, 32'hC01, 32'h408, 0), 0, 0);
        wait_done();

        // Back-to-back with CMD_VALID held, then a pulse while busy is ignored.
        n0 = n_rsp;
        send(OP_IDLE, 4'd3, 8'h00, mk(8'h00, 3, 32'h0, 32'h0, 0), 1, 0);
        send(OP_DR, 4'd1, 8'h01, mk(8'h00, 6, 32'h19, 32'h08, 0), 0, 1);
        cmd_valid = 1'b1; cmd_op = OP_RESET; cmd_len = 4'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done();
        repeat (20) @(negedge clk);
        chk("b2b_rsp_count", n_rsp - n0, 32'd2);

        // Zero length: immediate response, no TCK.
        send(OP_DR, 4'd0, 8'hFF, mk(8'h00, 0, 32'h0, 32'h0, 1), 0, 0);
        wait_done();

        // Over-long length clamps to 8 shift bits.
        send(OP_DR, 4'd15, 8'hA5, mk(8'h4A, 13, 32'hC01, 32'h528, 0), 0, 0);
        wait_done();

        // Commanded reset responds with zero data.
        send(OP_RESET, 4'd0, 8'h00, mk(8'h00, 6, 32'h1F, 32'h0, 0), 0, 0);
        wait_done();

        // RST during shift bit 3 of SHIFT_DR.
        send(OP_DR, 4'd8, 8'hFF, mk(8'hFE, 13, 32'hC01, 32'h7F8, 0), 0, 0);
        w = 0;
        while (rec_n < 7 && w < 500) begin @(negedge clk); w++; end
        chk("midrst_reached_bit3", {31'd0, rec_n >= 7}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_tck", {31'd0, tck}, 32'd0);
        chk("midrst_tms", {31'd0, tms}, 32'd1);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        rec_clear();
        wait_ready();
        chk("midrst_tck_count", rec_n, 32'd6);
        chk("midrst_tms_seq", rec_tms, 32'h1F);
        rec_clear();

        // Normal operation resumes after the re-run reset.
        send(OP_IR, 4'd4, 8'h0D, mk(8'h0A, 10, 32'h183, 32'hD0, 0), 0, 0);
        wait_done();
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jtag_driver.md
Name: jtag_driver

Overview:
- JTAG master sequencer that sits directly upstream of the ics TAP controller.
- Generates TCK, TMS, TDI and optionally TRST from a system clock, and captures TDO.
- Accepts simple commands over a valid/ready interface: reset TAP, shift IR, shift DR, idle N cycles.
- Returns the captured TDO bits as a one-cycle response.

Parameters:
- DATA_W, 8: maximum shift length and width of CMD_DATA/RSP_DATA.
- CLK_DIV, 2: CLK cycles per TCK half-period (>=1).
- LEN_W, $clog2(DATA_W)+1: width of CMD_LEN.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous reset, active-high.
- CMD_VALID  input  1  command request.
- CMD_READY  output  1  block idle; command accepted when CMD_VALID&CMD_READY on a CLK edge.
- CMD_OP  input  2  0=RESET, 1=SHIFT_IR, 2=SHIFT_DR, 3=IDLE.
- CMD_LEN  input  LEN_W  bit count (SHIFT) or TCK count (IDLE).
- CMD_DATA  input  DATA_W  TDI bits, LSB shifted first.
- RSP_VALID  output  1  one-CLK pulse when a command completes.
- RSP_DATA  output  DATA_W  captured TDO bits, right-aligned, upper bits 0; held until next completion.
- BUSY  output  1  equal to ~CMD_READY.
- TCK  output  1  JTAG clock; low when idle.
- TMS  output  1  JTAG mode select.
- TDI  output  1  JTAG data to TAP.
- TDO  input  1  JTAG data from TAP.
- TRST  output  1  TAP reset, active-high (only with JTAG_TRST_EN).

Behaviour:
- Reset values: TCK=0, TMS=1, TDI=0, TRST=0, CMD_READY=0, RSP_VALID=0, RSP_DATA=0.
- After RST deasserts, the block autonomously runs the RESET sequence. CMD_READY rises when it finishes; no RSP_VALID is issued for this auto-reset.
- TCK bit period = 2*CLK_DIV CLK cycles: a low phase of CLK_DIV cycles, then a high phase of CLK_DIV cycles.
- TMS/TDI change only at the start of the low phase (the TCK falling edge, or the start of the first bit).
- TDO is sampled on the CLK edge where TCK rises.
- States: IDLE, PRE, SHIFT, POST, WAIT.
  - IDLE: TMS=0, TCK low.
  - PRE, SHIFT, POST, WAIT: per-bit TMS tables below. Each entry takes one TCK period.
- RESET op:
  - TMS=1 for 5 TCK, then TMS=0 for 1 TCK; the TAP ends in Run-Test/Idle.
  - Total 6 TCK.
- SHIFT_DR op:
  - PRE: TMS = 1,0,0.
  - SHIFT: LEN bits with TDI = CMD_DATA[i] and TMS=0, except the last bit, which has TMS=1 (Exit1).
  - POST: TMS = 1,0 (Update, Run-Test/Idle).
  - Total 3+LEN+2 TCK.
- SHIFT_IR op:
  - PRE: TMS = 1,1,0,0.
  - SHIFT and POST as for SHIFT_DR.
  - Total 4+LEN+2 TCK.
- IDLE op: LEN TCK periods with TMS=0.
- TDI:
  - Outside SHIFT, TDI=0.
  - During SHIFT, TDO sampled on bit i is written to RSP_DATA[i].
- LEN handling:
  - LEN=0 on any non-RESET op: completes one CLK after accept, with no TCK pulses and RSP_DATA=0.
  - LEN>DATA_W is clamped to DATA_W.
- Completion: RSP_VALID pulses for one CLK, and CMD_READY goes high in the same cycle. A new command may be accepted on the following edge.
- Busy: CMD_VALID while BUSY is ignored. CMD_DATA/OP/LEN are latched on accept, so later input changes have no effect.
- Illegal op codes: none exist; all 4 encodings are defined.
- RST mid-operation: outputs return to their reset values on the next CLK, any in-flight command is dropped with no RSP_VALID, and the auto-reset sequence reruns.

Optional Feature:
- Macro: JTAG_TRST_EN.
- Defined:
  - TRST port exists.
  - Every RESET sequence (auto or commanded) first drives TRST=1 for 1 full TCK period with TCK low, then TRST=0, then the 6-TCK TMS sequence.
- Undefined: no TRST port; reset relies on TMS only.

Test Plan:
- Auto-reset: RST high 3 CLK, then low with CLK_DIV=2 -> exactly 6 TCK pulses with TMS=1,1,1,1,1,0, then CMD_READY=1 with no RSP_VALID. With JTAG_TRST_EN, TRST is high 4 CLK before the first TCK.
- SHIFT_IR, LEN=4, DATA=4'b0010 -> TMS per TCK = 1,1,0,0,0,0,0,1,1,0; TDI during SHIFT = 0,1,0,0; 10 TCK total; RSP_VALID once.
- SHIFT_DR, LEN=8, DATA=0x81, TDO looped to TDI delayed by one TCK (model register) -> TMS = 1,0,0, then 0x7 followed by 1, then 1,0; RSP_DATA = TDO samples in LSB-first order (0x02 for a zero-initialised delay stage).
- Back-to-back: CMD_VALID held high with IDLE LEN=3, then SHIFT_DR LEN=1 -> second command accepted the cycle after the first RSP_VALID. CMD_VALID pulsed while BUSY is ignored (RSP_VALID count = 2).
- Edge lengths: SHIFT_DR LEN=0 -> RSP_VALID 1 CLK after accept, no TCK, RSP_DATA=0. LEN=15 with DATA_W=8 -> exactly 8 shift bits.
- RST asserted mid SHIFT_DR bit 3 -> next CLK TCK=0, TMS=1, no RSP_VALID; full 6-TCK reset follows and CMD_READY returns to 1.
